// File: rtl/hazard_scoreboard_pkg.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard_pkg
// Opcode constants shared by the pipeline stages, plus a small helper for
// sizing parameters that derive from several latencies.
// ----------------------------------------------------------------------------
package hazard_scoreboard_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // funct7 that selects the MUL/DIV group inside OP
    localparam logic [6:0] MULDIV_F7  = 7'h01;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_src_decode.sv
// ----------------------------------------------------------------------------
// inst_src_decode
// Purely combinational decode of which register sources an instruction
// really reads, and whether it is a long-latency writer (load / MUL-DIV).
// Ports:
//   i_inst       instruction word
//   o_rs1/o_rs2  source register fields
//   o_rs1_used   rs1 is actually read by this opcode
//   o_rs2_used   rs2 is actually read by this opcode
//   o_is_load    LOAD opcode
//   o_is_muldiv  OP with the MUL/DIV funct7
//   o_rd         destination register field
// ----------------------------------------------------------------------------
module inst_src_decode
    import hazard_scoreboard_pkg::*;
(
    input  logic [31:0] i_inst,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2,
    output logic        o_rs1_used,
    output logic        o_rs2_used,
    output logic        o_is_load,
    output logic        o_is_muldiv,
    output logic [4:0]  o_rd
);
    logic [6:0] w_opcode;
    logic [6:0] w_funct7;
    // funct3 plays no part in source usage
    logic [2:0] w_unused_funct3;

    assign w_opcode        = i_inst[6:0];
    assign w_funct7        = i_inst[31:25];
    assign w_unused_funct3 = i_inst[14:12];
    assign o_rs1           = i_inst[19:15];
    assign o_rs2           = i_inst[24:20];
    assign o_rd            = i_inst[11:7];

    always_comb begin
        o_rs1_used  = 1'b0;
        o_rs2_used  = 1'b0;
        o_is_load   = 1'b0;
        o_is_muldiv = 1'b0;
        case (w_opcode)
            OPC_LOAD: begin
                o_rs1_used = 1'b1;
                o_is_load  = 1'b1;
            end
            OPC_STORE, OPC_BRANCH: begin
                o_rs1_used = 1'b1;
                o_rs2_used = 1'b1;
            end
            OPC_OP: begin
                o_rs1_used  = 1'b1;
                o_rs2_used  = 1'b1;
                o_is_muldiv = (w_funct7 == MULDIV_F7);
            end
            OPC_OP_IMM, OPC_JALR: begin
                o_rs1_used = 1'b1;
            end
            // LUI, AUIPC, JAL and unknown opcodes read no register
            default: begin
                o_rs1_used = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard
// ID-stage hazard detector. Keeps a countdown per architectural register for
// in-flight loads and MUL/DIV results and stalls the instruction in ID while
// it reads a not-yet-forwardable register or would overtake an older,
// longer-latency write to the same rd.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   dec_inst     instruction in ID
//   dec_valid    dec_inst is a real instruction
//   flush        ID instruction squashed this cycle
//   freeze       whole pipeline held; scoreboard holds
//   stall        hold PC/IF-ID, bubble into EX
//   busy_mask    bit r set while register r is pending (bit 0 always 0)
//   stall_cnt    saturating count of non-frozen stall cycles
// ----------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int LOAD_LAT    = 1,
    parameter int MUL_LAT     = 3,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            dec_inst,
    input  logic                   dec_valid,
    input  logic                   flush,
    input  logic                   freeze,
    output logic                   stall,
    output logic [31:0]            busy_mask,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    // At least one bit so the array stays legal when both latencies are 0
    localparam int MAX_LAT = max_int(max_int(LOAD_LAT, MUL_LAT), 1);
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    logic [4:0]       w_rs1, w_rs2, w_rd;
    logic             w_rs1_used, w_rs2_used, w_is_load, w_is_muldiv;
    logic             w_writer, w_raw, w_waw, w_issue;
    logic [CNT_W-1:0] w_lat;
    logic [CNT_W-1:0] r_cnt [1:31];
    logic [CNT_W-1:0] w_cnt [0:31];   // x0 reads as permanently idle
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    inst_src_decode u_decode (
        .i_inst      (dec_inst),
        .o_rs1       (w_rs1),
        .o_rs2       (w_rs2),
        .o_rs1_used  (w_rs1_used),
        .o_rs2_used  (w_rs2_used),
        .o_is_load   (w_is_load),
        .o_is_muldiv (w_is_muldiv),
        .o_rd        (w_rd)
    );

    always_comb begin
        w_lat = '0;
        if (w_is_load)
            w_lat = CNT_W'(LOAD_LAT);
        else if (w_is_muldiv)
            w_lat = CNT_W'(MUL_LAT);
    end

    assign w_writer = (w_is_load | w_is_muldiv) && (w_rd != 5'd0);

    assign w_raw = (w_rs1_used && (w_rs1 != 5'd0) && (w_cnt[w_rs1] != '0)) ||
                   (w_rs2_used && (w_rs2 != 5'd0) && (w_cnt[w_rs2] != '0));
    // An older write still further out than ours would land after us
    assign w_waw = w_writer && (w_cnt[w_rd] > w_lat);

    assign stall   = dec_valid && !flush && (w_raw || w_waw);
    assign w_issue = dec_valid && !stall && !flush && !freeze;

    assign w_cnt[0]     = '0;
    assign busy_mask[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt[gi] <= '0;
                end else if (!freeze) begin
                    if (w_issue && w_writer && (w_rd == 5'(gi)) && (w_lat != '0))
                        r_cnt[gi] <= w_lat;
                    else if (r_cnt[gi] != '0)
                        r_cnt[gi] <= r_cnt[gi] - 1'b1;
                end
            end
            assign w_cnt[gi]     = r_cnt[gi];
            assign busy_mask[gi] = (r_cnt[gi] != '0);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (stall && !freeze && (r_stall_cnt != {STALL_CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dec_inst;
    logic        dec_valid;
    logic        flush;
    logic        freeze;
    logic        stall, stall_s;
    logic [31:0] busy_mask, busy_mask_s;
    logic [31:0] stall_cnt;
    logic [3:0]  stall_cnt_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .rst(rst), .dec_inst(dec_inst), .dec_valid(dec_valid),
        .flush(flush), .freeze(freeze), .stall(stall),
        .busy_mask(busy_mask), .stall_cnt(stall_cnt)
    );

    hazard_scoreboard #(.STALL_CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .dec_inst(dec_inst), .dec_valid(dec_valid),
        .flush(flush), .freeze(freeze), .stall(stall_s),
        .busy_mask(busy_mask_s), .stall_cnt(stall_cnt_s)
    );

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] i_lw(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'b010, rd, 7'b0000011};
    endfunction
    function automatic logic [31:0] i_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'h00, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] i_mul(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'h01, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] i_sw(input logic [4:0] rs2, input logic [4:0] rs1);
        return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
    endfunction
    function automatic logic [31:0] i_lui(input logic [4:0] rd);
        return {20'h00001, rd, 7'b0110111};
    endfunction
    function automatic logic [31:0] i_jal(input logic [4:0] rd);
        return {20'h00000, rd, 7'b1101111};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; dec_valid = 1'b0; flush = 1'b0; freeze = 1'b0; dec_inst = 32'h0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    // issue one instruction (caller guarantees it does not stall)
    task automatic issue(input logic [31:0] inst);
        dec_inst = inst; dec_valid = 1'b1;
        tick();
        dec_valid = 1'b0;
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", stall); end
        checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL reset_busy got=%h exp=0", busy_mask); end
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
        $display("test_reset done");
    endtask

    task automatic test_load_use();
        do_reset();
        dec_inst = i_lw(5'd5, 5'd0); dec_valid = 1'b1; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_issue_stall got=%0b exp=0", stall); end
        tick();
        dec_inst = i_add(5'd6, 5'd5, 5'd1); #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_t1_stall got=%0b exp=1", stall); end
        checks++; if (busy_mask !== 32'h20) begin errors++; $display("FAIL lu_t1_busy got=%h exp=00000020", busy_mask); end
        tick();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_t2_stall got=%0b exp=0", stall); end
        tick();
        dec_valid = 1'b0; #1;
        checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL lu_cnt got=%0d exp=1", stall_cnt); end
        $display("test_load_use done");
    endtask

    task automatic test_src_usage();
        logic [31:0] insts [7];
        logic        exp   [7];
        insts[0] = i_lui(5'd5);            exp[0] = 1'b0;
        insts[1] = i_jal(5'd5);            exp[1] = 1'b0;
        insts[2] = i_sw(5'd7, 5'd0);       exp[2] = 1'b0;
        insts[3] = i_sw(5'd5, 5'd7);       exp[3] = 1'b1;
        insts[4] = {12'd0, 5'd5, 3'd0, 5'd1, 7'b1111111}; exp[4] = 1'b0; // unknown opcode
        insts[5] = i_add(5'd6, 5'd5, 5'd1); exp[5] = 1'b1;
        insts[6] = i_lw(5'd9, 5'd5);       exp[6] = 1'b1;
        do_reset();
        issue(i_lw(5'd5, 5'd0));
        dec_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            dec_inst = insts[k]; #1;
            checks++;
            if (stall !== exp[k]) begin errors++; $display("FAIL src_use[%0d] inst=%h got=%0b exp=%0b", k, insts[k], stall, exp[k]); end
        end
        // flushed dependent never stalls
        dec_inst = i_add(5'd6, 5'd5, 5'd1); flush = 1'b1; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL src_flush got=%0b exp=0", stall); end
        flush = 1'b0; dec_valid = 1'b0;
        tick();
        issue(i_lw(5'd0, 5'd1));
        checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL x0_busy got=%h exp=0", busy_mask); end
        dec_inst = i_add(5'd1, 5'd0, 5'd0); dec_valid = 1'b1; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL x0_stall got=%0b exp=0", stall); end
        dec_valid = 1'b0;
        $display("test_src_usage done");
    endtask

    task automatic test_mul();
        logic exp_stall [5];
        exp_stall[0] = 1'b1; exp_stall[1] = 1'b1; exp_stall[2] = 1'b1; exp_stall[3] = 1'b0; exp_stall[4] = 1'b0;
        do_reset();
        issue(i_mul(5'd8, 5'd1, 5'd2));
        dec_inst = i_add(5'd9, 5'd8, 5'd8); dec_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (stall !== exp_stall[k] || busy_mask[8] !== exp_stall[k]) begin
                errors++;
                $display("FAIL mul_t%0d stall=%0b busy8=%0b exp=%0b", k + 1, stall, busy_mask[8], exp_stall[k]);
            end
            tick();
        end
        dec_valid = 1'b0; #1;
        checks++; if (stall_cnt !== 32'd3) begin errors++; $display("FAIL mul_cnt got=%0d exp=3", stall_cnt); end
        // WAW: lw x8 behind a pending mul x8
        do_reset();
        issue(i_mul(5'd8, 5'd1, 5'd2));
        dec_inst = i_lw(5'd8, 5'd1); dec_valid = 1'b1;
        for (int k = 1; k < 4; k++) begin
            #1;
            checks++;
            if (stall !== exp_stall[k]) begin errors++; $display("FAIL waw_t%0d got=%0b exp=%0b", k, stall, exp_stall[k]); end
            tick();
        end
        dec_valid = 1'b0; #1;
        checks++; if (busy_mask !== 32'h100) begin errors++; $display("FAIL waw_busy got=%h exp=00000100", busy_mask); end
        $display("test_mul done");
    endtask

    task automatic test_freeze();
        do_reset();
        issue(i_lw(5'd5, 5'd0));
        dec_inst = i_add(5'd6, 5'd5, 5'd1); dec_valid = 1'b1; freeze = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (stall !== 1'b1 || busy_mask !== 32'h20 || stall_cnt !== 32'd0) begin
                errors++;
                $display("FAIL frz_%0d stall=%0b busy=%h cnt=%0d exp 1/00000020/0", k, stall, busy_mask, stall_cnt);
            end
            tick();
        end
        freeze = 1'b0; #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL frz_rel_stall got=%0b exp=1", stall); end
        tick();
        checks++; if (stall !== 1'b0 || stall_cnt !== 32'd1) begin errors++; $display("FAIL frz_after stall=%0b cnt=%0d exp 0/1", stall, stall_cnt); end
        dec_valid = 1'b0;
        $display("test_freeze done");
    endtask

    task automatic test_flush_rst();
        do_reset();
        dec_inst = i_lw(5'd7, 5'd1); dec_valid = 1'b1; flush = 1'b1; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got=%0b exp=0", stall); end
        tick();
        flush = 1'b0; dec_valid = 1'b0; #1;
        checks++; if (busy_mask[7] !== 1'b0) begin errors++; $display("FAIL flush_busy7 got=%0b exp=0", busy_mask[7]); end
        issue(i_mul(5'd8, 5'd1, 5'd2));
        dec_inst = i_add(5'd9, 5'd8, 5'd0); dec_valid = 1'b1;
        tick();
        checks++; if (stall_cnt !== 32'd1 || busy_mask !== 32'h100) begin errors++; $display("FAIL pre_rst cnt=%0d busy=%h exp 1/00000100", stall_cnt, busy_mask); end
        rst = 1'b1;
        tick();
        rst = 1'b0; dec_valid = 1'b0; #1;
        checks++; if (busy_mask !== 32'h0 || stall_cnt !== 32'd0) begin errors++; $display("FAIL mid_rst busy=%h cnt=%0d exp 0/0", busy_mask, stall_cnt); end
        $display("test_flush_rst done");
    endtask

    task automatic test_saturate();
        do_reset();
        // self-dependent mul chain: issue, 3 stalls, issue, ...
        dec_inst = i_mul(5'd10, 5'd10, 5'd10); dec_valid = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        checks++; if (stall_cnt_s !== 4'd15) begin errors++; $display("FAIL sat_20 got=%0d exp=15", stall_cnt_s); end
        for (int k = 0; k < 20; k++) tick();
        checks++; if (stall_cnt_s !== 4'd15) begin errors++; $display("FAIL sat_40 got=%0d exp=15", stall_cnt_s); end
        checks++; if (stall_cnt !== 32'd30) begin errors++; $display("FAIL chain_40 got=%0d exp=30", stall_cnt); end
        dec_valid = 1'b0;
        $display("test_saturate done");
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_src_usage();
        test_mul();
        test_freeze();
        test_flush_rst();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
